// File: rtl/arm_pkg.sv
// Shared ARM immediate-format definitions: encoder FSM states, field widths
// and the 32-bit rotate used by both the encoder and its reference model.
package arm_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam int ROT_W = 4;
  localparam int IMM8_W = 8;
  localparam logic [ROT_W-1:0] ROT_MAX = 4'd15;

  // Rotate left with wrap; the doubled word keeps amount 0 free of shift-by-width.
  function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
    logic [63:0] dbl;
    dbl = {value, value} << amount;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/imm12_encoder.sv
// Iterative encoder for ARM data-processing immediates: tries one rotation per
// cycle and returns the smallest-rot {rot, imm8} encoding, or flags the value.
module imm12_encoder
  import arm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              value,
  output logic                     busy,
  output logic                     done,
  output logic                     valid,
  output logic [ROT_W+IMM8_W-1:0]  imm12
);

  state_t           state;
  logic [31:0]      val_q;
  logic [ROT_W-1:0] rot;
  logic [31:0]      cand;
  logic             fits;

  // Undo the decoder's right rotation by 2*rot; a fit leaves only the low byte set.
  assign cand = rol32(val_q, {rot, 1'b0});
  assign fits = (cand[31:IMM8_W] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      val_q <= '0;
      rot   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      imm12 <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            val_q <= value;
            rot   <= '0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (fits) begin
            imm12 <= {rot, cand[IMM8_W-1:0]};
            valid <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (rot == ROT_MAX) begin
            imm12 <= '0;
            valid <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rot <= rot + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm12_encoder.sv
// Self-checking bench for imm12_encoder: directed latency/encoding vectors,
// start-while-busy, mid-search reset, and a round-trip sweep.
module tb_imm12_encoder;
  import arm_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [11:0] imm12;

  int errors;
  int checks;

  imm12_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .imm12 (imm12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one encode: start raised in an IDLE cycle (cycle 0), returns the cycle
  // in which done was seen (-1 on timeout). Optionally re-pulses start in
  // cycles 1-3 and scrambles value once the search is under way.
  task automatic run_encode(input logic [31:0] v, input logic poke,
                            output int lat, output logic got_valid,
                            output logic [11:0] got_imm, output logic busy_c1);
    int cyc;
    @(posedge clk); #1;
    value = v;
    start = 1'b1;
    lat = -1;
    got_valid = 1'bx;
    got_imm = 'x;
    busy_c1 = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      start = (poke && cyc <= 3) ? 1'b1 : 1'b0;
      value = $urandom;
      if (cyc == 1) busy_c1 = busy;
      if (done) begin
        lat = cyc;
        got_valid = valid;
        got_imm = imm12;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Reference: first rot whose left rotation by 2*rot fits in eight bits.
  function automatic logic [12:0] ref_encode(input logic [31:0] v);
    logic [31:0] c;
    for (int r = 0; r < 16; r++) begin
      c = rol32(v, 5'(2 * r));
      if (c[31:8] == 24'h0) return {1'b1, 4'(r), c[7:0]};
    end
    return 13'h0000;
  endfunction

  function automatic logic [31:0] decode_imm12(input logic [11:0] e);
    logic [4:0] amt;
    amt = 5'(32 - 2 * int'(e[11:8]));
    return rol32({24'h0, e[7:0]}, amt);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; value = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, valid, imm12} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b valid=%b imm12=%h, need all zero",
               busy, done, valid, imm12);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vals [6] = '{32'h000000FF, 32'hF000000F, 32'hFF000000,
                              32'h000003FC, 32'h00000101, 32'h00000000};
    int          lats [6] = '{2, 4, 6, 17, 17, 2};
    logic        vlds [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] imms [6] = '{12'h0FF, 12'h2FF, 12'h4FF, 12'hFFF, 12'h000, 12'h000};
    int lat; logic gv; logic [11:0] gi; logic b1;
    for (int i = 0; i < 6; i++) begin
      run_encode(vals[i], (i == 1), lat, gv, gi, b1);
      checks++;
      if (lat != lats[i]) begin
        errors++;
        $display("[TB] FAIL latency[%h]: got %0d, need %0d", vals[i], lat, lats[i]);
      end
      checks++;
      if (gv !== vlds[i] || gi !== imms[i]) begin
        errors++;
        $display("[TB] FAIL result[%h]: got valid=%b imm12=%h, need valid=%b imm12=%h",
                 vals[i], gv, gi, vlds[i], imms[i]);
      end
      checks++;
      if (b1 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL busy_search[%h]: got %b, need 1", vals[i], b1);
      end
    end
    // Result must hold in the following IDLE cycle.
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b1 || imm12 !== 12'h000) begin
      errors++;
      $display("[TB] FAIL hold_idle: got busy=%b done=%b valid=%b imm12=%h, need 0 0 1 000",
               busy, done, valid, imm12);
    end
  endtask

  task automatic test_reset_mid_search();
    int lat; logic gv; logic [11:0] gi; logic b1;
    int seen_done;
    @(posedge clk); #1;
    value = 32'h00000101;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, valid, imm12} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_search: got busy=%b done=%b valid=%b imm12=%h, need all zero",
               busy, done, valid, imm12);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("[TB] FAIL no_done_after_reset: got %0d active cycles, need 0", seen_done);
    end
    run_encode(32'h000000FF, 1'b0, lat, gv, gi, b1);
    checks++;
    if (lat != 2 || gv !== 1'b1 || gi !== 12'h0FF) begin
      errors++;
      $display("[TB] FAIL restart_after_reset: got lat=%0d valid=%b imm12=%h, need 2 1 0FF",
               lat, gv, gi);
    end
  endtask

  task automatic test_sweep();
    int lat; logic gv; logic [11:0] gi; logic b1;
    logic [31:0] v;
    logic [12:0] exp;
    int bad_res, bad_lat, bad_rt;
    bad_res = 0; bad_lat = 0; bad_rt = 0;
    for (int n = 0; n < 1500; n++) begin
      // Half the vectors are built encodable so the valid path gets real coverage.
      if (n % 2 == 0) v = rol32({24'h0, 8'($urandom)}, 5'($urandom_range(0, 31)));
      else v = $urandom;
      exp = ref_encode(v);
      run_encode(v, 1'b0, lat, gv, gi, b1);
      if (gv !== exp[12] || gi !== exp[11:0]) bad_res++;
      if (lat != (exp[12] ? int'(exp[11:8]) + 2 : 17)) bad_lat++;
      if (gv === 1'b1 && decode_imm12(gi) !== v) bad_rt++;
    end
    checks++;
    if (bad_res != 0) begin
      errors++;
      $display("[TB] FAIL sweep_result: got %0d wrong encodings, need 0", bad_res);
    end
    checks++;
    if (bad_lat != 0) begin
      errors++;
      $display("[TB] FAIL sweep_latency: got %0d wrong latencies, need 0", bad_lat);
    end
    checks++;
    if (bad_rt != 0) begin
      errors++;
      $display("[TB] FAIL sweep_roundtrip: got %0d decode mismatches, need 0", bad_rt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    start = 1'b0;
    value = '0;
    test_reset();
    test_directed();
    test_reset_mid_search();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
